mdu_issue_ctrl: RTL
===================

# mdu_issue_ctrl

Issue/sequencing controller between the EX-stage M-extension decode and the iterative 32x32 multiplier core. Accepts one RV32M multiply request at a time (MUL, MULH, MULHSU, MULHU), converts signed operands to magnitudes, pulses the core's start, and waits for its done. It then applies the sign fixup, selects the low or high word, and presents a tagged result to the write-back stage over a valid/ready handshake. The block also drives the pipeline stall signal.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- TAG_W, 5: width of the destination tag (rd index) carried with the request.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  abort the in-flight op; has priority over every other input.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_funct3  in  3  RV32M funct3; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is unsupported.
- req_rs1, req_rs2  in  XLEN  operand values.
- req_tag  in  TAG_W  destination tag.
- mul_start  out  1  one-cycle start pulse to the multiplier core.
- mul_op1, mul_op2  out  XLEN  unsigned magnitudes; registered; stable from ISSUE until WAIT exits.
- mul_done  in  1  core completion, level; cleared by the core on start.
- mul_product  in  2*XLEN  unsigned 64-bit product; valid while mul_done=1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  write-back accepts the result.
- rsp_data  out  XLEN  result word.
- rsp_tag  out  TAG_W  tag captured at accept.
- rsp_err  out  1  unsupported funct3; rsp_data=0.
- busy  out  1  pipeline stall; high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, FIXUP, RESP.
- IDLE:
  - Accepts when req_valid=1. Captures funct3, tag, operand signs, magnitudes, and neg = sign1^sign2.
  - Sign handling: rs1 is signed for 001/010; rs2 is signed for 001 only.
  - Magnitude of a negative operand is its 32-bit two's-complement negation. 0x80000000 maps to 0x80000000 (2^31 unsigned).
  - Next state: RESP if funct3[2]=1 (rsp_err=1, data 0); otherwise ISSUE.
- ISSUE: mul_start=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - mul_done is sampled only in this state.
  - On mul_done=1, register mul_product and go to FIXUP.
- FIXUP:
  - p = neg ? (~product + 1) mod 2^64 : product.
  - rsp_data = p[31:0] for funct3 000; p[63:32] otherwise. Go to RESP.
  - MUL ignores neg; the low word is sign-invariant.
- RESP:
  - rsp_valid=1; rsp_data, rsp_tag and rsp_err are held stable.
  - On rsp_ready=1, go to IDLE.
- flush:
  - In any state, go to IDLE next cycle with rsp_valid=0; no response is issued.
  - No wait for the core: the next ISSUE restarts it. A stale mul_done is never sampled outside WAIT.
- Reset values: state IDLE, mul_start=0, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_tag=0, mul_op1=mul_op2=0, busy=0. req_ready=1 from the first cycle after reset.

## Timing
- Accept at edge T0 (IDLE, req_valid=1). ISSUE in cycle T0+1, with mul_start high in that cycle.
- If mul_done is first sampled high in cycle D: FIXUP in D+1, rsp_valid high from D+2.
- Latency from accept to rsp_valid = core latency + 3 cycles.
- Unsupported funct3: rsp_valid is high in the cycle after accept.
- Throughput: one op per response.
  - A new request is accepted no earlier than the cycle after the RESP handshake.
  - req_ready=0 while rsp_valid=1.
- rsp_valid=1 with rsp_ready=0: the response stalls indefinitely with all rsp_* outputs unchanged.
- flush and rsp_ready high together in RESP: the flush wins, but the result has already been handed off. Write-back must treat a same-cycle flush as discard.

## Configuration
- MDU_ZERO_BYPASS_EN defined:
  - In IDLE, if funct3[2]=0 and either operand is zero, skip ISSUE/WAIT/FIXUP.
  - Go directly to RESP with rsp_data=0 and rsp_err=0. mul_start is not pulsed.
  - Latency is 1 cycle.
- Undefined: zero operands follow the normal ISSUE/WAIT/FIXUP path, with no functional difference in rsp_data.

## Test plan
- MUL 7 x 6, core model with 32-cycle latency -> rsp_data=0x0000002A, rsp_tag echoed, rsp_valid 35 cycles after accept, one mul_start pulse.
- MULH 0xFFFFFFFF x 0xFFFFFFFF (-1 x -1) -> mul_op1=mul_op2=1, rsp_data=0x00000000.
- MULHSU 0x80000000 x 0xFFFFFFFF -> magnitudes 0x80000000/0xFFFFFFFF, neg=1, rsp_data=0x80000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> rsp_data=0xFFFFFFFE; then hold rsp_ready=0 for 10 cycles -> outputs stable and req_ready=0 throughout.
- funct3=100 -> rsp_err=1, rsp_data=0, no mul_start; flush asserted in WAIT with mul_done stale high afterwards -> no rsp_valid, IDLE next cycle.
- MDU_ZERO_BYPASS_EN: MUL 0 x 0x1234 -> rsp_valid the cycle after accept, data 0, no mul_start; without the macro -> full-latency path, data 0.

Source files
------------

// File: rtl/mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl
//
// Issue/sequencing controller between the EX-stage M-extension decode and an
// iterative 32x32 unsigned multiplier core. It accepts one RV32M multiply
// request at a time (MUL, MULH, MULHSU, MULHU), turns signed operands into
// unsigned magnitudes, pulses the core's start, and waits for its done. It
// then negates the 64-bit product when the operand signs differ, selects the
// low or high word, and offers a tagged result to write-back over a
// valid/ready handshake. busy stalls the pipeline while an op is in flight.
//
// Optional feature (compile-time macro MDU_ZERO_BYPASS_EN):
//   when defined, a supported request with a zero operand skips the core and
//   answers with rsp_data=0 in the cycle after accept.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   flush           abort any in-flight op; highest priority after rst
//   req_valid       request present
//   req_ready       high only while idle
//   req_funct3      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx unsupported
//   req_rs1/rs2     operand values
//   req_tag         destination tag, echoed on rsp_tag
//   mul_start       one-cycle start pulse to the core
//   mul_op1/op2     unsigned magnitudes presented to the core
//   mul_done        core completion (level)
//   mul_product     unsigned 2*XLEN product, valid while mul_done=1
//   rsp_valid       result available
//   rsp_ready       write-back accepts the result
//   rsp_data        result word
//   rsp_tag         tag captured at accept
//   rsp_err         unsupported funct3 (rsp_data=0)
//   busy            pipeline stall; high whenever not idle
// ---------------------------------------------------------------------------
module mdu_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_funct3,
  input  logic [XLEN-1:0]    req_rs1,
  input  logic [XLEN-1:0]    req_rs2,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               mul_start,
  output logic [XLEN-1:0]    mul_op1,
  output logic [XLEN-1:0]    mul_op2,
  input  logic               mul_done,
  input  logic [2*XLEN-1:0]  mul_product,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [XLEN-1:0]    rsp_data,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [XLEN-1:0]   ZERO_X  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X  = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ZERO_2X = {(2*XLEN){1'b0}};
  localparam logic [TAG_W-1:0]  ZERO_T  = {TAG_W{1'b0}};

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which read as unsigned is exactly 2^(XLEN-1).
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_neg);
    logic [XLEN-1:0] m;
    if (is_neg) begin
      m = ~v + ONE_X;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Applies the sign to the unsigned product and picks the result word.
  // MUL never sets neg, and its low word would be sign-invariant anyway.
  function automatic logic [XLEN-1:0] fixup_word(input logic [2*XLEN-1:0] prod,
                                                 input logic              is_neg,
                                                 input logic              low_word);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   w;
    if (is_neg) begin
      p = ~prod + ONE_2X;
    end else begin
      p = prod;
    end
    if (low_word) begin
      w = p[XLEN-1:0];
    end else begin
      w = p[2*XLEN-1:XLEN];
    end
    return w;
  endfunction

  state_t              state_r, state_s;
  logic                low_r,   low_s;
  logic                neg_r,   neg_s;
  logic [XLEN-1:0]     op1_r,   op1_s;
  logic [XLEN-1:0]     op2_r,   op2_s;
  logic [2*XLEN-1:0]   prod_r,  prod_s;
  logic [XLEN-1:0]     data_r,  data_s;
  logic                err_r,   err_s;
  logic [TAG_W-1:0]    tag_r,   tag_s;
  logic                start_r;
  logic                valid_r;
  logic                busy_r;
  logic                ready_r;

  logic                sign1_s;
  logic                sign2_s;
  logic                zero_op_s;

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH.
  assign sign1_s = req_rs1[XLEN-1] &
                   ((req_funct3 == 3'b001) || (req_funct3 == 3'b010));
  assign sign2_s = req_rs2[XLEN-1] & (req_funct3 == 3'b001);

`ifdef MDU_ZERO_BYPASS_EN
  // A zero operand forces a zero result in every supported op.
  assign zero_op_s = (req_rs1 == ZERO_X) || (req_rs2 == ZERO_X);
`else
  assign zero_op_s = 1'b0;
`endif

  // Next-state and next-value logic for the sequencing FSM.
  always_comb begin
    state_s = state_r;
    low_s   = low_r;
    neg_s   = neg_r;
    op1_s   = op1_r;
    op2_s   = op2_r;
    prod_s  = prod_r;
    data_s  = data_r;
    err_s   = err_r;
    tag_s   = tag_r;
    if (flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            tag_s = req_tag;
            low_s = (req_funct3 == 3'b000);
            neg_s = sign1_s ^ sign2_s;
            if (req_funct3[2]) begin
              state_s = ST_RESP;
              data_s  = ZERO_X;
              err_s   = 1'b1;
            end else if (zero_op_s) begin
              state_s = ST_RESP;
              data_s  = ZERO_X;
              err_s   = 1'b0;
            end else begin
              state_s = ST_ISSUE;
              err_s   = 1'b0;
              op1_s   = magnitude(req_rs1, sign1_s);
              op2_s   = magnitude(req_rs2, sign2_s);
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_s = ST_WAIT;
        end
        ST_WAIT: begin
          // The only state that looks at mul_done, so a done left high by a
          // flushed op can never be taken for the current one.
          if (mul_done) begin
            prod_s  = mul_product;
            state_s = ST_FIXUP;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_FIXUP: begin
          data_s  = fixup_word(prod_r, neg_r, low_r);
          state_s = ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RESP;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register, captured operands/results and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      low_r   <= 1'b0;
      neg_r   <= 1'b0;
      op1_r   <= ZERO_X;
      op2_r   <= ZERO_X;
      prod_r  <= ZERO_2X;
      data_r  <= ZERO_X;
      err_r   <= 1'b0;
      tag_r   <= ZERO_T;
      start_r <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      low_r   <= low_s;
      neg_r   <= neg_s;
      op1_r   <= op1_s;
      op2_r   <= op2_s;
      prod_r  <= prod_s;
      data_r  <= data_s;
      err_r   <= err_s;
      tag_r   <= tag_s;
      // ISSUE is only ever entered from IDLE and lasts one cycle, so this
      // yields a single start pulse per op.
      start_r <= (state_s == ST_ISSUE);
      valid_r <= (state_s == ST_RESP);
      busy_r  <= (state_s != ST_IDLE);
      ready_r <= (state_s == ST_IDLE);
    end
  end

  assign req_ready = ready_r;
  assign mul_start = start_r;
  assign mul_op1   = op1_r;
  assign mul_op2   = op2_r;
  assign rsp_valid = valid_r;
  assign rsp_data  = data_r;
  assign rsp_tag   = tag_r;
  assign rsp_err   = err_r;
  assign busy      = busy_r;

endmodule
